digit_frame_streamer: RTL and testbench



---
 rtl/digit_frame_streamer.sv | 220 ++++++++++++++++++++++
 tb/tb_digit_frame_streamer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_frame_streamer.sv
// Streams a frame of DIGITS_NUM glyphs, column by column, to an OLED byte driver,
// then a sync strobe. Holds one pending value so the next frame can queue up.
module digit_frame_streamer #(
    parameter int unsigned DIGITS_NUM    = 6,
    parameter int unsigned GLYPH_W       = 21,
    parameter int unsigned GLYPH_H_BYTES = 4,
    parameter int unsigned GAP_COLS      = 0,
    localparam int unsigned DpW = $clog2(DIGITS_NUM + 1),
    localparam int unsigned XW  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
    localparam int unsigned YW  = (GLYPH_H_BYTES > 1) ? $clog2(GLYPH_H_BYTES) : 1
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [4*DIGITS_NUM-1:0] digits,
    input  logic                    blank_en,
    input  logic [DpW-1:0]          dp_pos,
    input  logic                    write_stb,
    output logic                    ready,
    output logic                    busy,
    output logic [4:0]              glyph_code,
    output logic                    glyph_dp,
    output logic [XW-1:0]           glyph_x,
    output logic [YW-1:0]           glyph_y,
    input  logic [7:0]              pixels_in,
    output logic [7:0]              oled_data,
    output logic                    oled_write_stb,
    output logic                    oled_sync_stb,
    input  logic                    oled_ready
);

    localparam int unsigned DW = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
    localparam int unsigned GW = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;
    localparam logic [DW-1:0] DMax = DW'(DIGITS_NUM - 1);
    localparam logic [XW-1:0] XMax = XW'(GLYPH_W - 1);
    localparam logic [YW-1:0] YMax = YW'(GLYPH_H_BYTES - 1);
    localparam logic [GW-1:0] GMax = GW'((GAP_COLS > 0) ? GAP_COLS - 1 : 0);
    localparam bit HasGap = (GAP_COLS > 0);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StSync,
        StWaitSync
    } state_e;

    state_e                  state_q, state_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*DIGITS_NUM-1:0] pend_digits_q, pend_digits_d;
    logic                    pend_blank_en_q, pend_blank_en_d;
    logic [DpW-1:0]          pend_dp_q, pend_dp_d;
    logic [4*DIGITS_NUM-1:0] act_digits_q, act_digits_d;
    logic [DpW-1:0]          act_dp_q, act_dp_d;
    logic [DIGITS_NUM-1:0]   blank_q, blank_d;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    in_gap_q, in_gap_d;

    logic [DIGITS_NUM-1:0] blank_new;
    logic [DW-1:0]         cur_idx;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic                  last_byte;

    // Blanking runs from the leftmost digit down; once a digit is kept, all lower ones are too.
    always_comb begin
        logic run;
        blank_new = '0;
        run       = pend_blank_en_q;
        for (int k = DIGITS_NUM - 1; k >= 0; k--) begin
            run = run && (pend_digits_q[4*k +: 4] == 4'h0) && (k != 0) &&
                  (pend_dp_q != DpW'(k + 1));
            blank_new[k] = run;
        end
    end

    assign cur_idx = DMax - dcnt_q;

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int k = 0; k < DIGITS_NUM; k++) begin
            if (cur_idx == DW'(k)) begin
                cur_nib   = act_digits_q[4*k +: 4];
                cur_blank = blank_q[k];
                cur_dp    = (act_dp_q == DpW'(k + 1));
            end
        end
    end

    assign last_byte = !in_gap_q && (y_q == YMax) && (x_q == XMax) && (dcnt_q == DMax);

    always_comb begin
        state_d         = state_q;
        pend_valid_d    = pend_valid_q;
        pend_digits_d   = pend_digits_q;
        pend_blank_en_d = pend_blank_en_q;
        pend_dp_d       = pend_dp_q;
        act_digits_d    = act_digits_q;
        act_dp_d        = act_dp_q;
        blank_d         = blank_q;
        dcnt_d          = dcnt_q;
        x_d             = x_q;
        y_d             = y_q;
        gap_d           = gap_q;
        in_gap_d        = in_gap_q;

        if (write_stb && !pend_valid_q) begin
            pend_valid_d    = 1'b1;
            pend_digits_d   = digits;
            pend_blank_en_d = blank_en;
            pend_dp_d       = dp_pos;
        end

        unique case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    state_d      = StSend;
                    pend_valid_d = 1'b0;
                    act_digits_d = pend_digits_q;
                    act_dp_d     = pend_dp_q;
                    blank_d      = blank_new;
                    dcnt_d       = '0;
                    x_d          = '0;
                    y_d          = '0;
                    gap_d        = '0;
                    in_gap_d     = 1'b0;
                end
            end
            StSend: begin
                if (!oled_ready) state_d = StWait;
            end
            StWait: begin
                if (oled_ready) begin
                    if (last_byte) begin
                        state_d = StSync;
                    end else begin
                        state_d = StSend;
                        if (y_q != YMax) begin
                            y_d = y_q + 1'b1;
                        end else begin
                            y_d = '0;
                            if (in_gap_q) begin
                                if (gap_q != GMax) begin
                                    gap_d = gap_q + 1'b1;
                                end else begin
                                    gap_d    = '0;
                                    in_gap_d = 1'b0;
                                    dcnt_d   = dcnt_q + 1'b1;
                                end
                            end else if (x_q != XMax) begin
                                x_d = x_q + 1'b1;
                            end else begin
                                x_d = '0;
                                if (HasGap) in_gap_d = 1'b1;
                                else dcnt_d = dcnt_q + 1'b1;
                            end
                        end
                    end
                end
            end
            StSync: begin
                if (!oled_ready) state_d = StWaitSync;
            end
            StWaitSync: begin
                if (oled_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q         <= StIdle;
            pend_valid_q    <= 1'b0;
            pend_digits_q   <= '0;
            pend_blank_en_q <= 1'b0;
            pend_dp_q       <= '0;
            act_digits_q    <= '0;
            act_dp_q        <= '0;
            blank_q         <= '0;
            dcnt_q          <= '0;
            x_q             <= '0;
            y_q             <= '0;
            gap_q           <= '0;
            in_gap_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_valid_q    <= pend_valid_d;
            pend_digits_q   <= pend_digits_d;
            pend_blank_en_q <= pend_blank_en_d;
            pend_dp_q       <= pend_dp_d;
            act_digits_q    <= act_digits_d;
            act_dp_q        <= act_dp_d;
            blank_q         <= blank_d;
            dcnt_q          <= dcnt_d;
            x_q             <= x_d;
            y_q             <= y_d;
            gap_q           <= gap_d;
            in_gap_q        <= in_gap_d;
        end
    end

    assign ready          = !pend_valid_q;
    assign busy           = (state_q != StIdle);
    assign oled_write_stb = (state_q == StSend);
    assign oled_sync_stb  = (state_q == StSync);
    assign glyph_code     = cur_blank ? 5'h10 : {1'b0, cur_nib};
    assign glyph_dp       = cur_dp;
    assign glyph_x        = x_q;
    assign glyph_y        = y_q;
    // Idle and gap columns emit zero bytes; the ROM byte is only passed while a glyph is out.
    assign oled_data = (((state_q == StSend) || (state_q == StWait)) && !in_gap_q) ?
                       pixels_in : 8'h00;

endmodule

// File: tb/tb_digit_frame_streamer.sv
// Scoreboarded bench for digit_frame_streamer: a frame-level model pushes expected
// bytes on each accepted write; a monitor pops and compares on every strobe.
module tb_digit_frame_streamer;

    localparam int N     = 6;
    localparam int W     = 21;
    localparam int H     = 4;
    localparam int GAP   = 2;
    localparam int BYTES = (N * W + (N - 1) * GAP) * H;

    typedef struct {
        bit         is_sync;
        bit         is_gap;
        logic [4:0] code;
        bit         dp;
        int         x;
        int         y;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] digits;
    logic        blank_en;
    logic [2:0]  dp_pos;
    logic        write_stb;
    logic        ready, busy;
    logic [4:0]  glyph_code;
    logic        glyph_dp;
    logic [4:0]  glyph_x;
    logic [1:0]  glyph_y;
    logic [7:0]  pixels_in;
    logic [7:0]  oled_data;
    logic        oled_write_stb, oled_sync_stb;
    logic        oled_ready;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   stall_mode = 0;

    always #5 clk = ~clk;

    digit_frame_streamer #(
        .DIGITS_NUM(N), .GLYPH_W(W), .GLYPH_H_BYTES(H), .GAP_COLS(GAP)
    ) dut (
        .clk_in(clk), .reset_n_in(rst_n), .digits(digits), .blank_en(blank_en),
        .dp_pos(dp_pos), .write_stb(write_stb), .ready(ready), .busy(busy),
        .glyph_code(glyph_code), .glyph_dp(glyph_dp), .glyph_x(glyph_x), .glyph_y(glyph_y),
        .pixels_in(pixels_in), .oled_data(oled_data), .oled_write_stb(oled_write_stb),
        .oled_sync_stb(oled_sync_stb), .oled_ready(oled_ready)
    );

    function automatic logic [7:0] rom(logic [4:0] c, logic dp, int x, int y);
        int v;
        v = int'(c) * 29 + x * 7 + y * 61 + (dp ? 128 : 0);
        return 8'(v) ^ 8'h5A;
    endfunction

    always_comb pixels_in = rom(glyph_code, glyph_dp, int'(glyph_x), int'(glyph_y));

    // Frame model: every digit above the highest one worth showing is blank.
    function automatic void push_frame(logic [23:0] dg, logic be, int dp);
        int   keep;
        exp_t e;
        logic [3:0] nib;
        keep = 0;
        for (int k = 0; k < N; k++) if (dg[4*k +: 4] != 4'h0) keep = k;
        if (dp - 1 > keep) keep = dp - 1;
        for (int d = N - 1; d >= 0; d--) begin
            nib = dg[4*d +: 4];
            for (int x = 0; x < W; x++) begin
                for (int y = 0; y < H; y++) begin
                    e.is_sync = 0;
                    e.is_gap  = 0;
                    e.code    = (be && d > keep) ? 5'h10 : {1'b0, nib};
                    e.dp      = (dp == d + 1);
                    e.x       = x;
                    e.y       = y;
                    e.data    = rom(e.code, e.dp, x, y);
                    sb.push_back(e);
                end
            end
            if (d != 0) begin
                for (int g = 0; g < GAP * H; g++) begin
                    e.is_sync = 0;
                    e.is_gap  = 1;
                    e.code    = 5'h00;
                    e.dp      = 0;
                    e.x       = 0;
                    e.y       = g % H;
                    e.data    = 8'h00;
                    sb.push_back(e);
                end
            end
        end
        e.is_sync = 1;
        e.is_gap  = 0;
        e.code    = 5'h00;
        e.dp      = 0;
        e.x       = 0;
        e.y       = 0;
        e.data    = 8'h00;
        sb.push_back(e);
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic do_write(logic [23:0] d, logic be, int dp, bit accept);
        @(negedge clk);
        digits    = d;
        blank_en  = be;
        dp_pos    = 3'(dp);
        write_stb = 1'b1;
        if (accept) push_frame(d, be, dp);
        @(negedge clk);
        write_stb = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n >= 10000), 0);
    endtask

    task automatic wait_level(string name, ref logic sig, input logic lvl);
        int n = 0;
        while (sig !== lvl && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n >= 10000), 0);
    endtask

    // Driver: acknowledge each strobe by dropping oled_ready for one cycle.
    initial begin
        bit d_pw, d_ps;
        int dly;
        oled_ready = 1'b1;
        d_pw = 0;
        d_ps = 0;
        forever begin
            @(negedge clk);
            if ((oled_write_stb && !d_pw) || (oled_sync_stb && !d_ps)) begin
                dly = stall_mode ? 5 : int'($urandom_range(1, 3));
                repeat (dly - 1) @(negedge clk);
                oled_ready = 1'b0;
                @(negedge clk);
                oled_ready = 1'b1;
            end
            d_pw = oled_write_stb;
            d_ps = oled_sync_stb;
        end
    end

    // Monitor
    initial begin
        bit   m_pw, m_ps;
        int   wcount;
        exp_t e;
        logic [7:0] h_data;
        logic [4:0] h_x, h_code;
        logic [1:0] h_y;
        m_pw = 0;
        m_ps = 0;
        wcount = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pw = 0;
                m_ps = 0;
                wcount = 0;
            end else begin
                if (oled_write_stb && !m_pw) begin
                    wcount++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got strobe data %0h, expected none",
                                 oled_data);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_sync || oled_data !== e.data || int'(glyph_x) != e.x ||
                            int'(glyph_y) != e.y ||
                            (!e.is_gap && (glyph_code !== e.code || glyph_dp !== e.dp))) begin
                            errors++;
                            $display({"FAIL byte %0d: got data=%0h code=%0h dp=%0b x=%0d y=%0d",
                                      ", expected sync=%0b data=%0h code=%0h dp=%0b x=%0d y=%0d"},
                                     wcount - 1, oled_data, glyph_code, glyph_dp, glyph_x,
                                     glyph_y, e.is_sync, e.data, e.code, e.dp, e.x, e.y);
                        end
                    end
                    h_data = oled_data;
                    h_x    = glyph_x;
                    h_y    = glyph_y;
                    h_code = glyph_code;
                end else if (oled_write_stb && m_pw) begin
                    checks++;
                    if (oled_data !== h_data || glyph_x !== h_x || glyph_y !== h_y ||
                        glyph_code !== h_code) begin
                        errors++;
                        $display("FAIL hold_stable: got data=%0h x=%0d y=%0d, expected %0h %0d %0d",
                                 oled_data, glyph_x, glyph_y, h_data, h_x, h_y);
                    end
                end
                if (oled_sync_stb && !m_ps) begin
                    checks++;
                    if (sb.size() == 0 || !sb[0].is_sync) begin
                        errors++;
                        $display("FAIL sync_order: got sync, expected %0d more bytes",
                                 sb.size());
                    end
                    if (sb.size() != 0) e = sb.pop_front();
                    chk("bytes_per_frame", wcount, BYTES);
                    wcount = 0;
                end
                m_pw = oled_write_stb;
                m_ps = oled_sync_stb;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d;
        int nz;
        rst_n     = 1'b0;
        digits    = '0;
        blank_en  = 1'b0;
        dp_pos    = '0;
        write_stb = 1'b0;
        #3;
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wstb", int'(oled_write_stb), 0);
        chk("rst_sstb", int'(oled_sync_stb), 0);
        chk("rst_data", int'(oled_data), 0);
        chk("rst_code", int'(glyph_code), 0);
        chk("rst_dp", int'(glyph_dp), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_write(24'h012345, 1'b1, 0, 1);
        chk("lat_ready_low", int'(ready), 0);
        chk("lat_idle", int'(busy), 0);
        @(negedge clk);
        chk("lat_wstb", int'(oled_write_stb), 1);
        chk("lat_ready_back", int'(ready), 1);
        wait_done("frame_012345");

        do_write(24'h000005, 1'b1, 2, 1);
        wait_done("frame_blank_dp");

        for (int i = 0; i < 6; i++) begin
            d  = 24'($urandom);
            nz = $urandom_range(0, 6);
            if (nz > 0) d = d & (24'hFFFFFF >> (4 * nz));
            do_write(d, 1'($urandom_range(0, 1)), $urandom_range(0, 6), 1);
            wait_done("frame_random");
        end

        stall_mode = 1;
        do_write(24'($urandom), 1'b0, 3, 1);
        wait_done("frame_stall");
        stall_mode = 0;

        do_write(24'h00A0B1, 1'b1, 0, 1);
        wait_level("b2b_busy", busy, 1'b1);
        do_write(24'h000C00, 1'b1, 5, 1);
        chk("b2b_ready_low", int'(ready), 0);
        do_write(24'hFFFFFF, 1'b0, 1, 0);
        chk("b2b_drop_ready", int'(ready), 0);
        wait_level("b2b_sync", oled_sync_stb, 1'b1);
        wait_level("b2b_exit", busy, 1'b0);
        @(negedge clk);
        chk("b2b_restart_busy", int'(busy), 1);
        chk("b2b_restart_wstb", int'(oled_write_stb), 1);
        wait_done("frame_b2b");

        do_write(24'h123456, 1'b0, 0, 1);
        do_write(24'h654321, 1'b0, 0, 1);
        wait_level("mid_send", oled_write_stb, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_wstb", int'(oled_write_stb), 0);
        chk("abort_sstb", int'(oled_sync_stb), 0);
        chk("abort_data", int'(oled_data), 0);
        chk("abort_code", int'(glyph_code), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_abort_idle", int'(busy), 0);
        chk("post_abort_ready", int'(ready), 1);

        do_write(24'h000000, 1'b1, 0, 1);
        wait_done("frame_zero");

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
